// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - configuration command and event handout bundle for tick_scheduler
interface tick_scheduler_if #(
    parameter int CW = 16,
    parameter int IW = 2
);
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_cmd;
    logic [IW-1:0] cfg_ch;
    logic          cfg_periodic;
    logic [CW-1:0] cfg_period;
    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_ch;

    modport master (
        output cfg_valid, cfg_cmd, cfg_ch, cfg_periodic, cfg_period, evt_ready,
        input  cfg_ready, evt_valid, evt_ch
    );

    modport slave (
        input  cfg_valid, cfg_cmd, cfg_ch, cfg_periodic, cfg_period, evt_ready,
        output cfg_ready, evt_valid, evt_ch
    );
endinterface

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - multi-channel one-shot/periodic timer on a shared base tick
// Expired channels are queued as pending and handed out one at a time, round-robin.
module tick_scheduler #(
    parameter int N_CH = 4,
    parameter int CW   = 16,
    parameter int IW   = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            tick,
    tick_scheduler_if.slave bus,
    output logic [N_CH-1:0] active,
    output logic [N_CH-1:0] overrun
);
    logic [N_CH-1:0] active_q, active_d;
    logic [N_CH-1:0] periodic_q, periodic_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic [CW-1:0]   period_q [N_CH];
    logic [CW-1:0]   period_d [N_CH];
    logic [CW-1:0]   count_q  [N_CH];
    logic [CW-1:0]   count_d  [N_CH];
    logic            evt_valid_q, evt_valid_d;
    logic [IW-1:0]   evt_ch_q, evt_ch_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            cfg_ready_q, cfg_ready_d;

    logic            cfg_fire, hs, found;
    logic [N_CH-1:0] wr, handed, expire, cand;
    logic [IW-1:0]   pick, idx;
    logic [CW-1:0]   start_period;

    assign cfg_fire     = bus.cfg_valid & cfg_ready_q;
    assign hs           = evt_valid_q & bus.evt_ready;
    assign start_period = (bus.cfg_period == '0) ? CW'(1) : bus.cfg_period;

    always_comb begin
        wr     = '0;
        handed = '0;
        expire = '0;
        for (int i = 0; i < N_CH; i++) begin
            wr[i]     = cfg_fire && (bus.cfg_ch == IW'(i));
            handed[i] = hs && (evt_ch_q == IW'(i));
            expire[i] = tick && active_q[i] && !wr[i] && (count_q[i] == CW'(1));
        end
    end

    // Channel state: a config write to a channel masks that channel's tick.
    always_comb begin
        active_d   = active_q;
        periodic_d = periodic_q;
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        period_d   = period_q;
        count_d    = count_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr[i]) begin
                pending_d[i] = 1'b0;
                if (bus.cfg_cmd) begin
                    active_d[i]   = 1'b1;
                    periodic_d[i] = bus.cfg_periodic;
                    period_d[i]   = start_period;
                    count_d[i]    = start_period;
                    overrun_d[i]  = 1'b0;
                end else begin
                    active_d[i] = 1'b0;
                end
            end else begin
                if (handed[i]) begin
                    pending_d[i] = 1'b0;
                end
                if (expire[i]) begin
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !handed[i]) begin
                        overrun_d[i] = 1'b1;
                    end
                    if (periodic_q[i]) begin
                        count_d[i] = period_q[i];
                    end else begin
                        active_d[i] = 1'b0;
                    end
                end else if (tick && active_q[i] && (count_q[i] > CW'(1))) begin
                    count_d[i] = count_q[i] - CW'(1);
                end
            end
        end
    end

    // Candidates come from registered pending, giving the two-cycle tick-to-event latency.
    always_comb begin
        cand  = pending_q & ~wr & ~(handed & ~expire);
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_CH; k++) begin
            if ((int'(ptr_q) + k) >= N_CH) begin
                idx = IW'(int'(ptr_q) + k - N_CH);
            end else begin
                idx = IW'(int'(ptr_q) + k);
            end
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        ptr_d       = ptr_q;
        cfg_ready_d = 1'b1;
        if (!evt_valid_q || hs) begin
            evt_valid_d = found;
            if (found) begin
                evt_ch_d = pick;
                ptr_d    = (pick == IW'(N_CH - 1)) ? '0 : pick + IW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active_q    <= '0;
            periodic_q  <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            ptr_q       <= '0;
            cfg_ready_q <= 1'b0;
        end else begin
            active_q    <= active_d;
            periodic_q  <= periodic_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            period_q    <= period_d;
            count_q     <= count_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            ptr_q       <= ptr_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_ch    = evt_ch_q;
    assign active        = active_q;
    assign overrun       = overrun_q;
endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Multi-channel event scheduler driven by one base tick pulse from a tick divider (e.g. 1 ms).
- Each of N_CH channels counts base ticks down from a programmed period, as a one-shot or periodic timer.
- Expired channels are queued as pending and handed out one event at a time over a valid/ready port, with round-robin arbitration.
- Sits between the tick divider and consumers (display refresh, debounce, sampling FSMs) so one prescaler serves many timers.

Parameters:
- N_CH, 4, number of channels (2..8).
- CW, 16, period/counter width in base ticks.
- IW, 2, channel index width; must satisfy 2^IW >= N_CH.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  base tick; one-cycle pulse, at most one per cycle.
- cfg_valid  in  1  configuration command present.
- cfg_ready  out  1  command accepted when cfg_valid & cfg_ready.
- cfg_cmd  in  1  0 = STOP, 1 = START.
- cfg_ch  in  IW  target channel; values >= N_CH are ignored but still accepted.
- cfg_periodic  in  1  START only: 1 = reload on expiry, 0 = one-shot.
- cfg_period  in  CW  START only: period in ticks; 0 is treated as 1.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event.
- evt_ch  out  IW  channel of the presented event.
- active  out  N_CH  per-channel running flag.
- overrun  out  N_CH  sticky; set when a channel expires while its event is still pending.

Behaviour:
- Reset (async assert, sync release): every count, period, periodic, pending and overrun bit is 0; active = 0; evt_valid = 0; evt_ch = 0; round-robin pointer = 0; cfg_ready = 0.
- cfg_ready goes to 1 on the first clock after release and stays 1.
- Per-channel state is {active, periodic, period, count, pending}.
- START accepted for ch: period <= max(cfg_period, 1); count <= same value; periodic <= cfg_periodic; active <= 1; pending <= 0; overrun[ch] <= 0.
- STOP accepted for ch: active <= 0; pending <= 0; overrun unchanged.
- Tick processing, for each active channel with no config write this cycle:
  - count > 1: count decrements.
  - count == 1 (expiry): pending <= 1. Periodic: count <= period. One-shot: active <= 0.
- A config write to the same channel in the same cycle as a tick wins; the tick is ignored for that channel.
- Overrun: expiry while pending = 1 and that event is not being handed out this cycle sets overrun[ch]; pending stays 1, so events merge.
- Expiry in the same cycle as that channel's handshake: pending stays 1, overrun is not set.
- Arbiter, evaluated each cycle when evt_valid = 0 or (evt_valid & evt_ready):
  - Pick the first pending channel at or after the pointer, wrapping modulo N_CH; exclude the channel being handed out this cycle unless it re-expires this cycle.
  - If one is found: evt_valid <= 1, evt_ch <= it, pointer <= it + 1 mod N_CH. Otherwise evt_valid <= 0.
- Handshake (evt_valid & evt_ready): pending[evt_ch] clears.
- While evt_valid = 1 and evt_ready = 0, evt_ch and evt_valid hold stable, including if that channel is STOPped. A STOPped channel's presented event is still delivered once.
- Latency: tick at cycle T expiring ch, with the output idle, gives pending at T+1 and evt_valid at T+2. Back-to-back events are possible with evt_ready held high.
- Throughput: at most one event per cycle. With evt_ready = 1 permanently, no channel waits more than N_CH-1 events.

Test Plan:
- Reset mid-count: START ch0 period 5, 3 ticks, pulse reset_n low → active = 0, evt_valid = 0 immediately; after release cfg_ready = 1 on the next clock, and no event appears on later ticks.
- One-shot: START ch1 period 3 one-shot, ticks every 10 cycles → exactly one event, evt_ch = 1, 2 cycles after the 3rd tick; active[1] = 0 afterward.
- Periodic and period-0: START ch2 periodic period 2, ch3 periodic period 0 → ch3 events on every tick, ch2 on every 2nd tick; on common ticks ch2 and ch3 events come on consecutive cycles in pointer order.
- Round-robin: all 4 channels periodic period 1, evt_ready = 1 → evt_ch sequence 0,1,2,3,0,1,… with no channel skipped.
- Overrun and stall: ch0 periodic period 1, evt_ready = 0 for 3 ticks → evt_valid held, evt_ch = 0, overrun[0] = 1; releasing ready gives one event only; a new START clears overrun[0].
- Same-cycle conflicts: START ch1 in the cycle of its expiring tick → no event, count = new period. STOP ch1 while its event is presented and stalled → the event is still delivered, then no further events.
